rv_mem_stage: RTL

- Parametrised memory pipeline stage for the RV core, sitting between execute and writeback.
- Registers execute results, generates byte-lane selects and replicated store data for XLEN = 32 or 64, and detects misaligned or illegal accesses.
- Runs a request/ack transaction on the data bus, then aligns and sign/zero-extends load data.
- Valid/ready handshakes on both pipeline sides let it stall on bus wait states and writeback back-pressure.

---
 rtl/rv_mem_stage_if.sv | 52 +++++
 rtl/rv_mem_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rv_mem_stage_if.sv
// Pipeline and data-bus signal bundle for rv_mem_stage.
// The stage uses the slave modport; the driving environment uses the master modport.
interface rv_mem_stage_if #(
  parameter int XLEN = 32
) ();
  localparam int SEL_W = XLEN / 8;

  logic             i_valid;
  logic             o_ready;
  logic [XLEN-1:0]  i_alu_result;
  logic             i_reg_write;
  logic             i_mem_read;
  logic             i_mem_write;
  logic [4:0]       i_rd;
  logic [1:0]       i_res_src;
  logic [2:0]       i_funct3;
  logic [XLEN-1:0]  i_rs2_val;

  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_alu_result;
  logic             o_reg_write;
  logic [4:0]       o_rd;
  logic [1:0]       o_res_src;
  logic [2:0]       o_funct3;
  logic [XLEN-1:0]  o_rdata;
  logic             o_fault;

  logic             o_bus_req;
  logic             o_bus_we;
  logic [XLEN-1:0]  o_bus_addr;
  logic [SEL_W-1:0] o_bus_sel;
  logic [XLEN-1:0]  o_bus_wdata;
  logic             i_bus_ack;
  logic [XLEN-1:0]  i_bus_rdata;

  modport master (
    output i_valid, i_alu_result, i_reg_write, i_mem_read, i_mem_write,
           i_rd, i_res_src, i_funct3, i_rs2_val, i_ready, i_bus_ack, i_bus_rdata,
    input  o_ready, o_valid, o_alu_result, o_reg_write, o_rd, o_res_src,
           o_funct3, o_rdata, o_fault, o_bus_req, o_bus_we, o_bus_addr,
           o_bus_sel, o_bus_wdata
  );

  modport slave (
    input  i_valid, i_alu_result, i_reg_write, i_mem_read, i_mem_write,
           i_rd, i_res_src, i_funct3, i_rs2_val, i_ready, i_bus_ack, i_bus_rdata,
    output o_ready, o_valid, o_alu_result, o_reg_write, o_rd, o_res_src,
           o_funct3, o_rdata, o_fault, o_bus_req, o_bus_we, o_bus_addr,
           o_bus_sel, o_bus_wdata
  );
endinterface

// File: rtl/rv_mem_stage.sv
// RV memory stage: lane select, store replication, fault check, load align/extend; result 1 cycle after accept (mem op: ack + 1).
// Back-pressure: bus fields held until ack, result held while i_ready is low; o_ready low in BUS.
module rv_mem_stage #(
  parameter  int XLEN    = 32,
  localparam int SEL_W   = XLEN / 8,
  localparam int ALIGN_W = $clog2(XLEN / 8)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rv_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state;

  logic               accept;
  logic               is_mem;
  logic               is_store;
  logic               misaligned;
  logic               illegal;
  logic               fault_in;
  logic [1:0]         size_in;
  logic [ALIGN_W-1:0] lane_in;
  logic [SEL_W-1:0]   sel_in;
  logic [XLEN-1:0]    wdata_in;

  logic [ALIGN_W-1:0] lane_q;
  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    mask;
  logic               sgn;
  logic [XLEN-1:0]    load_val;

  assign bus.o_ready = (state == IDLE) || ((state == DONE) && bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready;

  assign size_in  = bus.i_funct3[1:0];
  assign lane_in  = bus.i_alu_result[ALIGN_W-1:0];
  assign is_mem   = bus.i_mem_read || bus.i_mem_write;
  assign is_store = bus.i_mem_write;
  assign illegal  = (XLEN == 32) && (size_in == 2'b11);
  assign fault_in = is_mem && (misaligned || illegal);

  always_comb begin
    misaligned = 1'b0;
    sel_in     = '1;
    wdata_in   = bus.i_rs2_val;
    case (size_in)
      2'b00: begin
        sel_in   = SEL_W'(1) << lane_in;
        wdata_in = {SEL_W{bus.i_rs2_val[7:0]}};
      end
      2'b01: begin
        misaligned = bus.i_alu_result[0];
        sel_in     = SEL_W'(3) << lane_in;
        wdata_in   = {(SEL_W/2){bus.i_rs2_val[15:0]}};
      end
      2'b10: begin
        misaligned = |bus.i_alu_result[1:0];
        sel_in     = SEL_W'(15) << lane_in;
        wdata_in   = {(SEL_W/4){bus.i_rs2_val[31:0]}};
      end
      default: begin
        misaligned = |bus.i_alu_result[2:0];
      end
    endcase
  end

  // Load path works off the registered address, since the bus address has its low bits cleared.
  assign lane_q  = bus.o_alu_result[ALIGN_W-1:0];
  assign shifted = bus.i_bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    mask = '0;
    sgn  = 1'b0;
    case (bus.o_funct3[1:0])
      2'b00: begin
        mask[7:0] = '1;
        sgn       = shifted[7];
      end
      2'b01: begin
        mask[15:0] = '1;
        sgn        = shifted[15];
      end
      2'b10: begin
        mask[31:0] = '1;
        sgn        = shifted[31];
      end
      default: begin
        mask = '1;
      end
    endcase
  end

  assign load_val = (shifted & mask) | ((sgn && !bus.o_funct3[2]) ? ~mask : '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= IDLE;
      bus.o_valid      <= 1'b0;
      bus.o_alu_result <= '0;
      bus.o_reg_write  <= 1'b0;
      bus.o_rd         <= '0;
      bus.o_res_src    <= '0;
      bus.o_funct3     <= '0;
      bus.o_rdata      <= '0;
      bus.o_fault      <= 1'b0;
      bus.o_bus_req    <= 1'b0;
      bus.o_bus_we     <= 1'b0;
      bus.o_bus_addr   <= '0;
      bus.o_bus_sel    <= '0;
      bus.o_bus_wdata  <= '0;
    end else if (accept) begin
      bus.o_alu_result <= bus.i_alu_result;
      bus.o_reg_write  <= bus.i_reg_write && !fault_in;
      bus.o_rd         <= bus.i_rd;
      bus.o_res_src    <= bus.i_res_src;
      bus.o_funct3     <= bus.i_funct3;
      bus.o_rdata      <= '0;
      bus.o_fault      <= fault_in;
      bus.o_bus_addr   <= {bus.i_alu_result[XLEN-1:ALIGN_W], {ALIGN_W{1'b0}}};
      bus.o_bus_sel    <= sel_in;
      bus.o_bus_wdata  <= wdata_in;
      if (is_mem && !fault_in) begin
        state         <= BUS;
        bus.o_valid   <= 1'b0;
        bus.o_bus_req <= 1'b1;
        bus.o_bus_we  <= is_store;
      end else begin
        state         <= DONE;
        bus.o_valid   <= 1'b1;
        bus.o_bus_req <= 1'b0;
        bus.o_bus_we  <= 1'b0;
      end
    end else begin
      case (state)
        BUS: begin
          if (bus.i_bus_ack) begin
            state         <= DONE;
            bus.o_valid   <= 1'b1;
            bus.o_bus_req <= 1'b0;
            bus.o_bus_we  <= 1'b0;
            if (!bus.o_bus_we) begin
              bus.o_rdata <= load_val;
            end
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state       <= IDLE;
            bus.o_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
